// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI-stream sink among
// NUM_SRC sources. The grant is held from the first beat of a packet to
// the beat carrying last, then the search pointer moves past the winner.
// The winning index travels with the data on m_axis_id.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4,
  parameter int CNT_W      = 8,
  localparam int ID_W      = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            s_axis_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]            s_axis_last,
  output logic [NUM_SRC-1:0]            s_axis_ready,
  output logic                          m_axis_valid,
  output logic [DATA_WIDTH-1:0]         m_axis_data,
  output logic                          m_axis_last,
  output logic [ID_W-1:0]               m_axis_id,
  input  logic                          m_axis_ready,
  output logic                          busy,
  output logic [CNT_W-1:0]              beat_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int              LAST_IDX  = NUM_SRC - 1;
  localparam logic [ID_W-1:0] LAST_ID   = LAST_IDX[ID_W-1:0];
  localparam logic [ID_W:0]   NUM_SRC_W = NUM_SRC[ID_W:0];

  state_t                  state, next_state;
  logic [ID_W-1:0]         grant;
  logic [ID_W-1:0]         ptr;
  logic [ID_W-1:0]         pick;
  logic [ID_W:0]           arb_sum;
  logic                    arb_hit;
  logic [NUM_SRC-1:0]      rot_valid;
  logic                    sel_valid;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_last;
  logic                    xfer;

  assign xfer = m_axis_valid & m_axis_ready;

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: one arbitration cycle in IDLE, leave BUSY on the last beat.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|s_axis_valid) next_state = BUSY;
      BUSY:    if (xfer && sel_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Round-robin search: rotate the request vector so ptr sits at bit 0, take
  // the lowest set bit, then map it back to a source index modulo NUM_SRC.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rot_valid = NUM_SRC'({s_axis_valid, s_axis_valid} >> ptr);
    arb_hit   = 1'b0;
    arb_sum   = '0;
    pick      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!arb_hit && rot_valid[i]) begin
        arb_hit = 1'b1;
        arb_sum = {1'b0, ptr} + i[ID_W:0];
        if (arb_sum >= NUM_SRC_W) arb_sum = arb_sum - NUM_SRC_W;
        pick    = ID_W'(arb_sum);
      end
    end
  end

  // Grant, pointer and saturating beat counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == IDLE && |s_axis_valid) begin
        grant    <= pick;
        beat_cnt <= '0;
      end
      if (xfer) begin
        if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
        if (sel_last) ptr <= (grant == LAST_ID) ? '0 : grant + 1'b1;
      end
    end
  end

  // Output logic: mux the granted source onto the sink, route ready back to it.
  always_comb begin
    sel_valid    = 1'b0;
    sel_data     = '0;
    sel_last     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == i[ID_W-1:0]) begin
        sel_valid = s_axis_valid[i];
        sel_data  = s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last  = s_axis_last[i];
      end
    end
    s_axis_ready = '0;
    m_axis_valid = 1'b0;
    m_axis_data  = '0;
    m_axis_last  = 1'b0;
    m_axis_id    = '0;
    busy         = 1'b0;
    if (state == BUSY) begin
      busy         = 1'b1;
      m_axis_valid = sel_valid;
      m_axis_data  = sel_data;
      m_axis_last  = sel_last;
      m_axis_id    = grant;
      for (int i = 0; i < NUM_SRC; i++) begin
        s_axis_ready[i] = m_axis_ready && (grant == i[ID_W-1:0]);
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: queue-driven source models feed the main
// instance, a per-source scoreboard checks every accepted beat, and a second
// instance with a 2-bit counter covers saturation.
module tb_axis_rr_arbiter;

  localparam int DW = 8;
  localparam int NS = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;

  logic [NS-1:0]    s_valid = '0;
  logic [NS*DW-1:0] s_data  = '0;
  logic [NS-1:0]    s_last  = '0;
  logic [NS-1:0]    s_ready;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic [1:0]       m_id;
  logic             m_ready = 1'b0;
  logic             busy;
  logic [7:0]       beat_cnt;

  logic [NS-1:0]    sat_s_valid = '0;
  logic [NS*DW-1:0] sat_s_data  = '0;
  logic [NS-1:0]    sat_s_last  = '0;
  logic [NS-1:0]    sat_s_ready;
  logic             sat_m_valid;
  logic [DW-1:0]    sat_m_data;
  logic             sat_m_last;
  logic [1:0]       sat_m_id;
  logic             sat_m_ready = 1'b1;
  logic             sat_busy;
  logic [1:0]       sat_beat_cnt;

  int errors = 0;
  int checks = 0;

  beat_t         src_q [NS][$];
  beat_t         exp_q [NS][$];
  logic [NS-1:0] hold = '0;
  logic [NS-1:0] pop  = '0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;
  logic [1:0]    prev_id    = '0;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last),
    .s_axis_ready(s_ready),
    .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_last(m_last),
    .m_axis_id(m_id), .m_axis_ready(m_ready),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .CNT_W(2)) sat_dut (
    .clk(clk), .reset(reset),
    .s_axis_valid(sat_s_valid), .s_axis_data(sat_s_data), .s_axis_last(sat_s_last),
    .s_axis_ready(sat_s_ready),
    .m_axis_valid(sat_m_valid), .m_axis_data(sat_m_data), .m_axis_last(sat_m_last),
    .m_axis_id(sat_m_id), .m_axis_ready(sat_m_ready),
    .busy(sat_busy), .beat_cnt(sat_beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue a packet on a source and the same beats on its scoreboard lane.
  task automatic send(input int src, input logic [DW-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.data = base + k[DW-1:0];
      b.last = (k == n - 1);
      src_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < NS; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = !busy && all_empty();
    end
    check("drain_done", {31'b0, done}, 1);
  endtask

  // Source models: retire the beat accepted at this edge, present the next one.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NS; i++) begin
      if (pop[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      if (src_q[i].size() != 0 && !hold[i]) begin
        s_valid[i]          = 1'b1;
        s_data[i*DW +: DW]  = src_q[i][0].data;
        s_last[i]           = src_q[i][0].last;
      end else begin
        s_valid[i]          = 1'b0;
        s_data[i*DW +: DW]  = '0;
        s_last[i]           = 1'b0;
      end
    end
  end

  // Mid-cycle monitor: scoreboard per source, stability under backpressure.
  always @(negedge clk) begin
    pop = s_valid & s_ready;
    if (reset && prev_stall) begin
      check("hold_valid", {31'b0, m_valid}, 1);
      check("hold_data", {24'b0, m_data}, {24'b0, prev_data});
      check("hold_last", {31'b0, m_last}, {31'b0, prev_last});
      check("hold_id", {30'b0, m_id}, {30'b0, prev_id});
    end
    if (reset && m_valid && m_ready) begin
      check("sb_beat_expected", {31'b0, exp_q[m_id].size() != 0}, 1);
      if (exp_q[m_id].size() != 0) begin
        beat_t e;
        e = exp_q[m_id].pop_front();
        check("sb_data", {24'b0, m_data}, {24'b0, e.data});
        check("sb_last", {31'b0, m_last}, {31'b0, e.last});
      end
    end
    prev_stall = reset && m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    prev_id    = m_id;
  end

  initial begin
    int  grants[$];
    int  run;
    bit  prev_busy;
    bit  found;

    // Reset with every source requesting: outputs stay zero.
    for (int k = 0; k < NS; k++) begin
      send(k, 8'(k * 16), 2);
      send(k, 8'(k * 16 + 8), 2);
    end
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_valid_seen", {28'b0, s_valid}, 32'hF);
    check("rst_m_valid", {31'b0, m_valid}, 0);
    check("rst_m_data", {24'b0, m_data}, 0);
    check("rst_m_last", {31'b0, m_last}, 0);
    check("rst_m_id", {30'b0, m_id}, 0);
    check("rst_s_ready", {28'b0, s_ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_beat_cnt", {24'b0, beat_cnt}, 0);

    tick();
    reset = 1'b1;
    @(negedge clk);
    check("release_idle", {31'b0, busy}, 0);
    @(negedge clk);
    check("first_grant_busy", {31'b0, busy}, 1);
    check("first_grant_id", {30'b0, m_id}, 0);

    // Round robin with all sources requesting 2-beat packets.
    grants.push_back(int'(m_id));
    run       = 1;
    prev_busy = 1'b1;
    for (int c = 0; c < 60 && grants.size() < 5; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        grants.push_back(int'(m_id));
        run = 1;
      end else if (busy) begin
        run++;
      end else if (prev_busy) begin
        check("rr_beat_cnt", {24'b0, beat_cnt}, 2);
        check("rr_busy_len", run, 2);
      end
      prev_busy = busy;
    end
    check("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < grants.size(); i++) check("rr_order", grants[i], i % NS);
    drain();

    // Lock and stall: source 2 drops valid mid-packet while source 1 waits.
    tick();
    send(2, 8'h10, 3);
    tick();
    send(1, 8'h20, 1);
    send(3, 8'h30, 1);
    @(negedge clk);
    check("lock_busy", {31'b0, busy}, 1);
    check("lock_id", {30'b0, m_id}, 2);
    check("lock_first_data", {24'b0, m_data}, 8'h10);
    check("lock_ready1", {31'b0, s_ready[1]}, 0);
    tick();
    hold[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_m_valid", {31'b0, m_valid}, 0);
      check("stall_id", {30'b0, m_id}, 2);
      check("stall_ready1", {31'b0, s_ready[1]}, 0);
      check("stall_beat_cnt", {24'b0, beat_cnt}, 1);
      tick();
    end
    hold[2] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = !busy;
    end
    check("stall_pkt_end", {31'b0, found}, 1);
    check("stall_pkt_beats", {24'b0, beat_cnt}, 3);
    found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clk);
      found = busy;
    end
    check("next_grant_seen", {31'b0, found}, 1);
    check("next_grant_id", {30'b0, m_id}, 3);
    drain();

    // Random downstream backpressure across all sources.
    send(0, 8'h60, 3);
    send(1, 8'h70, 2);
    send(2, 8'h80, 1);
    send(3, 8'h90, 4);
    for (int c = 0; c < 30; c++) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
    end
    tick();
    m_ready = 1'b1;
    drain();

    // Mid-packet reset: ptr is 2 before the reset, must be 0 afterwards.
    tick();
    send(1, 8'h38, 1);
    send(1, 8'h40, 4);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      found = m_valid && m_ready && (m_id == 2'd1) && (m_data == 8'h41);
    end
    check("mid_second_beat_seen", {31'b0, found}, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("midrst_m_valid", {31'b0, m_valid}, 0);
    check("midrst_m_data", {24'b0, m_data}, 0);
    check("midrst_m_id", {30'b0, m_id}, 0);
    check("midrst_s_ready", {28'b0, s_ready}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_beat_cnt", {24'b0, beat_cnt}, 0);
    send(3, 8'hA0, 1);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_idle", {31'b0, busy}, 0);
    @(negedge clk);
    check("midrst_regrant_busy", {31'b0, busy}, 1);
    check("midrst_regrant_id", {30'b0, m_id}, 1);
    drain();

    // Saturation on the 2-bit counter instance with a 6-beat packet.
    tick();
    sat_s_valid[0]    = 1'b1;
    sat_s_data[7:0]   = 8'h50;
    sat_s_last[0]     = 1'b0;
    tick();
    check("sat_grant_busy", {31'b0, sat_busy}, 1);
    check("sat_grant_cnt", {30'b0, sat_beat_cnt}, 0);
    for (int k = 0; k < 6; k++) begin
      #1;
      check("sat_data", {24'b0, sat_m_data}, 32'h50 + k);
      tick();
      check("sat_beat_cnt", {30'b0, sat_beat_cnt}, (k < 3) ? k + 1 : 3);
      if (k < 5) begin
        sat_s_data[7:0] = 8'h51 + k[7:0];
        sat_s_last[0]   = (k == 4);
      end else begin
        sat_s_valid[0]  = 1'b0;
        sat_s_data[7:0] = '0;
        sat_s_last[0]   = 1'b0;
      end
    end
    check("sat_back_idle", {31'b0, sat_busy}, 0);
    tick();
    check("sat_cnt_held", {30'b0, sat_beat_cnt}, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
